video_timing_gen: RTL and testbench

- Parametrised successor to the menu core's fixed raster counter.
- Generates pixel clock-enable, H/V counters, blank, sync, DE and frame strobe for four vertical modes: NTSC/PAL × native/scandoubled.
- Horizontal geometry is set by parameters.
- Mode changes are deferred to a frame boundary, so outputs never see a torn frame.
- Feeds the pattern generator and the VGA_* outputs of any core in the codebase.

---
 rtl/video_timing_pkg.sv | 34 +++
 rtl/video_timing_if.sv | 28 ++
 rtl/video_ce_div.sv | 25 ++
 rtl/video_timing_gen.sv | 129 ++++++++++++
 tb/tb_video_timing_gen.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and vertical timing tables for the raster timing generator.
package video_timing_pkg;

  localparam int unsigned VMODE_W = 10;

  // Mode index is {pal, scandouble}.
  localparam logic [1:0] MODE_NTSC    = 2'b00;
  localparam logic [1:0] MODE_NTSC_2X = 2'b01;
  localparam logic [1:0] MODE_PAL     = 2'b10;
  localparam logic [1:0] MODE_PAL_2X  = 2'b11;

  typedef struct packed {
    logic [VMODE_W-1:0] v_total;
    logic [VMODE_W-1:0] vbl_start;
    logic [VMODE_W-1:0] vs_start;
    logic [VMODE_W-1:0] vs_end;
  } vmode_t;

  localparam vmode_t VMODE_TBL [4] = '{
    '{v_total: 10'd262, vbl_start: 10'd240, vs_start: 10'd245, vs_end: 10'd248},
    '{v_total: 10'd524, vbl_start: 10'd480, vs_start: 10'd490, vs_end: 10'd496},
    '{v_total: 10'd312, vbl_start: 10'd300, vs_start: 10'd304, vs_end: 10'd308},
    '{v_total: 10'd624, vbl_start: 10'd601, vs_start: 10'd609, vs_end: 10'd617}
  };

  function automatic vmode_t vmode_lookup(input logic [1:0] mode);
    return VMODE_TBL[mode];
  endfunction

  function automatic logic mode_is_2x(input logic [1:0] mode);
    return (mode == MODE_NTSC_2X) || (mode == MODE_PAL_2X);
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster timing bundle: mode request in, timing/strobe outputs back to the consumer.
interface video_timing_if #(
  parameter int unsigned CNT_W = 10
) ();
  logic             pal;
  logic             scandouble;
  logic             ce_pix;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic             hblank;
  logic             vblank;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             frame_stb;
  logic             field;
  logic [1:0]       cur_mode;

  modport master (
    input  pal, scandouble,
    output ce_pix, hc, vc, hblank, vblank, hsync, vsync, de, frame_stb, field, cur_mode
  );

  modport slave (
    output pal, scandouble,
    input  ce_pix, hc, vc, hblank, vblank, hsync, vsync, de, frame_stb, field, cur_mode
  );
endinterface

// File: rtl/video_ce_div.sv
// Pixel clock-enable generator: every clock (div1) or every other clock, low in reset.
module video_ce_div (
  input  logic clk,
  input  logic reset,
  input  logic div1,
  output logic ce
);

  logic ce_q, ce_d;

  always_comb begin
    ce_d = div1 ? 1'b1 : ~ce_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_q <= 1'b0;
    end else begin
      ce_q <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for NTSC/PAL x native/scandoubled; mode switches only at frame wrap.
// Define VIDEO_TIMING_INTERLACE_EN for alternating fields (native modes) with a half-line vsync.
module video_timing_gen #(
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned H_TOTAL       = 638,
  parameter int unsigned H_BLANK_START = 529,
  parameter int unsigned H_SYNC_START  = 544,
  parameter int unsigned H_SYNC_END    = 590
) (
  input logic            clk_sys,
  input logic            reset,
  video_timing_if.master vid
);
  import video_timing_pkg::*;

  if (!(H_BLANK_START < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END < H_TOTAL &&
        64'(H_TOTAL) <= (64'd1 << CNT_W) && CNT_W >= VMODE_W)) begin : g_geom_check
    $error("video_timing_gen: invalid horizontal geometry or counter width");
  end

  localparam logic [CNT_W-1:0] HLast       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HBlankStart = CNT_W'(H_BLANK_START);
  localparam logic [CNT_W-1:0] HSyncStart  = CNT_W'(H_SYNC_START);
  localparam logic [CNT_W-1:0] HSyncEnd    = CNT_W'(H_SYNC_END);
`ifdef VIDEO_TIMING_INTERLACE_EN
  localparam logic [CNT_W-1:0] HHalf       = CNT_W'(H_TOTAL / 2);
`endif

  logic             ce;
  logic [1:0]       mode_q, mode_d;
  logic             field_q, field_d;
  logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [CNT_W-1:0] v_last, vs_hc;
  logic             wrap;
  logic             hblank_q, vblank_q, hsync_q, vsync_q, de_q, frame_stb_q;
  vmode_t           vm;

  assign vm = vmode_lookup(mode_q);

  // Cadence follows the latched mode, so it switches one clock after a wrap.
  video_ce_div u_ce_div (
    .clk   (clk_sys),
    .reset (reset),
    .div1  (mode_is_2x(mode_q)),
    .ce    (ce)
  );

  always_comb begin
    v_last = CNT_W'(vm.v_total) - CNT_W'(1);
    vs_hc  = HSyncStart;
`ifdef VIDEO_TIMING_INTERLACE_EN
    // Field 1 carries the extra line and a vsync shifted by half a line.
    v_last = v_last + CNT_W'(field_q);
    if (field_q) vs_hc = HHalf;
`endif
  end

  always_comb begin
    hc_d    = hc_q;
    vc_d    = vc_q;
    mode_d  = mode_q;
    field_d = field_q;
    wrap    = ce && (hc_q == HLast) && (vc_q == v_last);
    if (ce) begin
      if (hc_q == HLast) begin
        hc_d = '0;
        vc_d = (vc_q == v_last) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
    if (wrap) begin
      mode_d = {vid.pal, vid.scandouble};
`ifdef VIDEO_TIMING_INTERLACE_EN
      field_d = ~mode_is_2x(mode_d) & ~field_q;
`endif
    end
  end

  // Flags are computed from the next counter values so they line up with hc/vc.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mode_q      <= {vid.pal, vid.scandouble};
      field_q     <= 1'b0;
      hc_q        <= '0;
      vc_q        <= '0;
      hblank_q    <= 1'b0;
      vblank_q    <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      frame_stb_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      field_q     <= field_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      hblank_q    <= (hc_d >= HBlankStart);
      vblank_q    <= (vc_d >= CNT_W'(vm.vbl_start));
      de_q        <= !(hc_d >= HBlankStart) && !(vc_d >= CNT_W'(vm.vbl_start));
      frame_stb_q <= wrap;
      if (hc_d == HSyncStart) begin
        hsync_q <= 1'b1;
      end else if (hc_d == HSyncEnd) begin
        hsync_q <= 1'b0;
      end
      if (hc_d == vs_hc) begin
        if (vc_d == CNT_W'(vm.vs_start)) begin
          vsync_q <= 1'b1;
        end else if (vc_d == CNT_W'(vm.vs_end)) begin
          vsync_q <= 1'b0;
        end
      end
    end
  end

  assign vid.ce_pix    = ce;
  assign vid.hc        = hc_q;
  assign vid.vc        = vc_q;
  assign vid.hblank    = hblank_q;
  assign vid.vblank    = vblank_q;
  assign vid.hsync     = hsync_q;
  assign vid.vsync     = vsync_q;
  assign vid.de        = de_q;
  assign vid.frame_stb = frame_stb_q;
  assign vid.field     = field_q;
  assign vid.cur_mode  = mode_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: linear-pixel-position reference model checked every clock,
// directed frame/sync measurements with literal expectations, then randomized mode/reset traffic.
module tb_video_timing_gen;

  localparam int CNT_W         = 10;
  localparam int H_TOTAL       = 8;
  localparam int H_BLANK_START = 4;
  localparam int H_SYNC_START  = 5;
  localparam int H_SYNC_END    = 6;
  localparam int BUDGET        = 12000;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  video_timing_if #(.CNT_W(CNT_W)) vif ();

  video_timing_gen #(
    .CNT_W         (CNT_W),
    .H_TOTAL       (H_TOTAL),
    .H_BLANK_START (H_BLANK_START),
    .H_SYNC_START  (H_SYNC_START),
    .H_SYNC_END    (H_SYNC_END)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .vid     (vif)
  );

  always #5 clk_sys = ~clk_sys;

  // Vertical tables indexed by {pal, scandouble}.
  int m_vt  [4] = '{262, 524, 312, 624};
  int m_vbl [4] = '{240, 480, 300, 601};
  int m_vss [4] = '{245, 490, 304, 609};
  int m_vse [4] = '{248, 496, 308, 617};

  // Model: m_p is the pixel's linear position within the frame.
  int       m_p     = 0;
  bit       m_ce    = 1'b0;
  bit [1:0] m_mode  = 2'b00;
  bit       m_field = 1'b0;
  bit       m_run   = 1'b0;
  bit       m_stb   = 1'b0;

  task automatic model_step(input bit rst, input bit [1:0] mode_in);
    int flen;
    if (rst) begin
      m_p = 0; m_ce = 1'b0; m_mode = mode_in; m_field = 1'b0; m_run = 1'b0; m_stb = 1'b0;
    end else begin
      flen  = H_TOTAL * (m_vt[m_mode] + int'(m_field));
      m_stb = m_ce && (m_p == flen - 1);
      m_run = 1'b1;
      if (m_ce) m_p = m_stb ? 0 : m_p + 1;
      m_ce = m_mode[0] ? 1'b1 : !m_ce;
      if (m_stb) begin
        m_mode = mode_in;
`ifdef VIDEO_TIMING_INTERLACE_EN
        m_field = !mode_in[0] && !m_field;
`endif
      end
    end
  endtask

  task automatic compare();
    int hc, vc, ev;
    bit e_hb, e_vb, e_hs, e_vs, e_de, ok;
    hc   = m_p % H_TOTAL;
    vc   = m_p / H_TOTAL;
    ev   = m_field ? H_TOTAL / 2 : H_SYNC_START;
    e_hb = m_run && (hc >= H_BLANK_START);
    e_vb = m_run && (vc >= m_vbl[m_mode]);
    e_de = m_run && !(hc >= H_BLANK_START) && !(vc >= m_vbl[m_mode]);
    e_hs = m_run && (hc >= H_SYNC_START) && (hc < H_SYNC_END);
    e_vs = m_run && (m_p >= m_vss[m_mode] * H_TOTAL + ev) && (m_p < m_vse[m_mode] * H_TOTAL + ev);
    ok = (vif.ce_pix == m_ce) && (int'(vif.hc) == hc) && (int'(vif.vc) == vc) &&
         (vif.hblank == e_hb) && (vif.vblank == e_vb) && (vif.hsync == e_hs) &&
         (vif.vsync == e_vs) && (vif.de == e_de) && (vif.frame_stb == m_stb) &&
         (vif.field == m_field) && (vif.cur_mode == m_mode);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model @%0t: dut ce=%0d hc=%0d vc=%0d hb=%0d vb=%0d hs=%0d vs=%0d de=%0d stb=%0d fld=%0d mode=%0d | want ce=%0d hc=%0d vc=%0d hb=%0d vb=%0d hs=%0d vs=%0d de=%0d stb=%0d fld=%0d mode=%0d",
               $time, vif.ce_pix, vif.hc, vif.vc, vif.hblank, vif.vblank, vif.hsync, vif.vsync,
               vif.de, vif.frame_stb, vif.field, vif.cur_mode, m_ce, hc, vc, e_hb, e_vb, e_hs,
               e_vs, e_de, m_stb, m_field, m_mode);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_sys);
      model_step(reset, {vif.pal, vif.scandouble});
      @(negedge clk_sys);
      compare();
    end
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within %0d clocks", name, BUDGET);
  endtask

  task automatic wait_stb(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!vif.frame_stb && n < BUDGET);
    if (!vif.frame_stb) timeout(name);
  endtask

  task automatic wait_line(input string name, input int line, input bit need_vs);
    int n = 0;
    while (!(int'(vif.vc) == line && (!need_vs || vif.vsync)) && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) timeout(name);
  endtask

  // Collects stats from the current cycle up to (excluding) the next frame_stb cycle.
  task automatic measure_frame(input string name, output int len, output int vc_max,
                               output int de_cnt, output int rise_vc, output int rise_hc,
                               output int vs_hi, output int mode_prev);
    bit prev_vs;
    len = 0; vc_max = 0; de_cnt = 0; rise_vc = -1; rise_hc = -1; vs_hi = 0;
    prev_vs = vif.vsync;
    mode_prev = int'(vif.cur_mode);
    do begin
      if (int'(vif.vc) > vc_max) vc_max = int'(vif.vc);
      if (vif.de && vif.ce_pix) de_cnt++;
      if (vif.vsync) vs_hi++;
      if (vif.vsync && !prev_vs && rise_vc < 0) begin
        rise_vc = int'(vif.vc);
        rise_hc = int'(vif.hc);
      end
      prev_vs   = vif.vsync;
      mode_prev = int'(vif.cur_mode);
      tick();
      len++;
    end while (!vif.frame_stb && len < BUDGET);
    if (!vif.frame_stb) timeout(name);
  endtask

  initial begin
    int n, len, vmax, dec, rvc, rhc, vhi, cm;
    vif.pal = 1'b0;
    vif.scandouble = 1'b0;
    reset = 1'b1;
    repeat (5) begin
      tick();
      check("reset ce_pix", int'(vif.ce_pix), 0);
      check("reset hc", int'(vif.hc), 0);
      check("reset vsync", int'(vif.vsync), 0);
      check("reset de", int'(vif.de), 0);
    end
    reset = 1'b0;
    tick();
    check("first ce after release", int'(vif.ce_pix), 1);
    check("hc held at 0", int'(vif.hc), 0);
    tick();
    check("ce toggles", int'(vif.ce_pix), 0);
    check("hc advanced", int'(vif.hc), 1);
    wait_stb("ntsc first stb", n);
    check("ntsc first frame clocks", n + 2, 4192);
`ifndef VIDEO_TIMING_INTERLACE_EN
    measure_frame("ntsc frame", len, vmax, dec, rvc, rhc, vhi, cm);
    check("ntsc period", len, 4192);
    check("ntsc vc peak", vmax, 261);
`endif

    // NTSC scandoubled
    vif.scandouble = 1'b1;
    wait_stb("2x latch", n);
    check("2x cur_mode", int'(vif.cur_mode), 1);
    measure_frame("2x first frame", len, vmax, dec, rvc, rhc, vhi, cm);
    measure_frame("2x frame", len, vmax, dec, rvc, rhc, vhi, cm);
    check("2x period", len, 4192);
    check("2x vc peak", vmax, 523);
    check("2x vsync rise vc", rvc, 490);
    check("2x vsync rise hc", rhc, H_SYNC_START);
    check("2x vsync clocks", vhi, 6 * H_TOTAL);

    // PAL native
    vif.pal = 1'b1;
    vif.scandouble = 1'b0;
    wait_stb("pal latch", n);
    check("pal cur_mode", int'(vif.cur_mode), 2);
    measure_frame("pal first frame", len, vmax, dec, rvc, rhc, vhi, cm);
    measure_frame("pal frame", len, vmax, dec, rvc, rhc, vhi, cm);
    check("pal de pixels", dec, H_BLANK_START * 300);
    check("pal period", len, 4992);
    check("pal vc peak", vmax, 311);

    // Mid-frame pal toggle waits for the frame wrap
    wait_line("pal line 100", 100, 1'b0);
    vif.pal = 1'b0;
    measure_frame("toggle frame", len, vmax, dec, rvc, rhc, vhi, cm);
    check("mode held to frame end", cm, 2);
    check("mode after wrap", int'(vif.cur_mode), 0);
`ifndef VIDEO_TIMING_INTERLACE_EN
    check("toggle frame vc peak", vmax, 311);
`endif

    // Reset in the middle of vsync
    wait_line("ntsc vsync line", 246, 1'b1);
    reset = 1'b1;
    tick();
    check("reset vsync cleared", int'(vif.vsync), 0);
    check("reset vc cleared", int'(vif.vc), 0);
    check("reset hsync cleared", int'(vif.hsync), 0);
    reset = 1'b0;
    wait_stb("post-reset stb", n);
    check("post-reset frame clocks", n, 4192);
`ifdef VIDEO_TIMING_INTERLACE_EN
    check("field 1 after wrap", int'(vif.field), 1);
    measure_frame("field1 frame", len, vmax, dec, rvc, rhc, vhi, cm);
    check("field1 period", len, 4208);
    check("field1 vc peak", vmax, 262);
    check("field1 vsync rise vc", rvc, 245);
    check("field1 vsync rise hc", rhc, H_TOTAL / 2);
    check("field 0 after wrap", int'(vif.field), 0);
    measure_frame("field0 frame", len, vmax, dec, rvc, rhc, vhi, cm);
    check("field0 period", len, 4192);
    check("field0 vsync rise hc", rhc, H_SYNC_START);
`else
    check("field stays 0", int'(vif.field), 0);
    measure_frame("clean frame", len, vmax, dec, rvc, rhc, vhi, cm);
    check("clean period", len, 4192);
    check("clean vsync rise vc", rvc, 245);
    check("clean vsync clocks", vhi, 3 * H_TOTAL * 2);
`endif

    // Randomized mode changes and reset pulses, checked by the model
    for (int i = 0; i < 10; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        reset = 1'b1;
        {vif.pal, vif.scandouble} = 2'($urandom_range(0, 3));
        repeat ($urandom_range(1, 3)) tick();
        reset = 1'b0;
      end else if (sel == 1) begin
        n = 0;
        while (!(int'(vif.hc) == H_TOTAL - 1 && vif.ce_pix && int'(vif.vc) >= 261) &&
               n < BUDGET) begin
          tick();
          n++;
        end
        if (n >= BUDGET) timeout("random line end");
        {vif.pal, vif.scandouble} = 2'($urandom_range(0, 3));
        tick();
      end else begin
        {vif.pal, vif.scandouble} = 2'($urandom_range(0, 3));
        repeat ($urandom_range(100, 2500)) tick();
      end
    end
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
